dice_roller: RTL and testbench
==============================

# dice_roller

Upstream stage of the dice game controller. Conditions the raw roll push-button into the debounced `Rb_o` level the controller consumes. Runs two free-running mod-6 die counters while the controller holds `roll_i` high. Presents the registered two-dice total on `sum_o` with a one-cycle `sum_valid_o` strobe when rolling stops. This replaces the behavioural stimulus source in front of the controller in the board-level build.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before `Rb_o` follows the button (must be ≥ 1).
- `clk` input, 1: system clock, all logic on rising edge.
- `rst` input, 1: reset. Synchronous, active-high, one clock.
- `btn_i` input, 1: raw roll button. Asynchronous, may bounce.
- `roll_i` input, 1: roll request from the dice game controller. Dice advance while high.
- `Rb_o` output, 1: debounced button level to the controller.
- `die1_o` output, 3: first die value, 1..6.
- `die2_o` output, 3: second die value, 1..6.
- `sum_o` output, 4: latched total `die1 + die2`, range 2..12.
- `sum_valid_o` output, 1: one-cycle strobe; `sum_o` is new this cycle.

## Operation
- **Reset values:**
  - `Rb_o` = 0
  - `die1_o` = 1, `die2_o` = 1
  - `sum_o` = 2
  - `sum_valid_o` = 0
  - debounce counter = 0
  - both synchronizer flops = 0
  - FSM = IDLE
- **Synchronizer:** two flops on `btn_i`. The second flop output is `btn_s`.
- **Debounce:**
  - When `btn_s` == `Rb_o`: the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES`, `Rb_o` toggles to `btn_s` and the counter clears.
  - Any bounce back to `Rb_o` before that clears the counter, so no output change.
- **Dice counters:**
  - On each edge with `roll_i` = 1, `die1` advances 1→2→…→6→1.
  - On the edge where `die1` wraps 6→1, `die2` advances one step with the same 6→1 wrap.
  - Both wrapping together (6,6)→(1,1) is legal.
  - With `roll_i` = 0, both dice hold.
- **FSM:**
  - IDLE: when `roll_i` = 1 → ROLLING. The dice advance on this same edge.
  - ROLLING: when `roll_i` = 1, stay. When `roll_i` = 0 → IDLE; on that edge `sum_o` ← `die1` + `die2` (held values) and `sum_valid_o` ← 1.
  - `sum_valid_o` is cleared on every other edge.
- **Width:** the sum is a zero-extended 3+3-bit add into 4 bits. The maximum of 12 never overflows.
- **`sum_o` hold:** `sum_o` holds between strobes. It does not track the dice while rolling.

## Timing
- `btn_i` to `Rb_o` latency: 2 (sync) + `DEBOUNCE_CYCLES` cycles for a clean edge.
- With `roll_i` high for N consecutive edges, `die1` advances N times. The total state advance is N mod 36.
- Strobe: `roll_i` is sampled low at edge k in ROLLING. Then `sum_o` and `sum_valid_o` = 1 are visible after edge k and `sum_valid_o` drops after edge k+1.
- A single-cycle `roll_i` pulse gives one die step and a strobe one cycle later.
- `rst` has priority over everything.
  - `rst` during ROLLING returns the FSM to IDLE with no strobe; the dice and `sum_o` take their reset values.
  - `rst` during debounce clears the counter and `Rb_o`.
- `roll_i` re-asserted on the cycle after the strobe: rolling restarts normally.
- The strobe and the debounce are independent. Both may change on the same edge.

## Structure
- Package `dice_pkg`:
  - `DIE_MIN` = 1, `DIE_MAX` = 6, `DIE_W` = 3, `SUM_W` = 4
  - FSM state enum {IDLE, ROLLING}
- Sub-module `button_debounce`: synchronizer plus counter, parameterised by `DEBOUNCE_CYCLES`, produces `Rb_o`.
- Dice counters, sum adder and FSM stay in the top module.

## Test plan
- **Button debounce:** reset, then `btn_i` bounces 1,0,1,0 on single cycles, then held 1. `Rb_o` stays 0 through the bounces and rises exactly 2+4 cycles after the stable 1 begins. It falls likewise after release.
- **Three-step roll:** from reset, `roll_i` = 1 for 3 cycles then 0. `die1` = 4, `die2` = 1, `sum_o` = 5, and `sum_valid_o` is high for exactly one cycle, one cycle after `roll_i` falls.
- **die1 wrap:** from reset, `roll_i` high for 6 cycles. `die1` wraps to 1, `die2` = 2, `sum_o` = 3. For 35 cycles: (6,6), `sum_o` = 12. For 36 cycles: (1,1), `sum_o` = 2.
- **Reset mid-roll:** `roll_i` high for 5 cycles, `rst` pulsed on cycle 3 while `roll_i` stays high 2 more cycles. After reset the dice are (1,1). The remaining 2 high cycles give (3,1), and there is exactly one strobe with `sum_o` = 4.
- **Back-to-back rolls:** `roll_i` 2 high, 1 low, 2 high, low. Strobes give `sum_o` = 4, then 6. `sum_o` holds 4 while the second roll is in progress.

Source files
------------

// File: rtl/dice_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dice_pkg
//  Description : Shared constants, FSM state type and die-step helper for the
//                dice roller front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package dice_pkg;

  localparam int DIE_W = 3;
  localparam int SUM_W = 4;

  localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
  localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    ROLLING = 1'b1
  } state_t;

  // One step of a die face: 1 -> 2 -> ... -> 6 -> 1
  function automatic logic [DIE_W-1:0] die_next(input logic [DIE_W-1:0] d);
    return (d == DIE_MAX) ? DIE_MIN : d + 3'd1;
  endfunction

endpackage : dice_pkg
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Two-flop synchronizer on the raw roll button followed by a
//                stability counter. The output only follows the synchronized
//                button after it has differed from the output for
//                DEBOUNCE_CYCLES consecutive clocks.
//  Ports       : clk, rst (sync, active-high)
//                btn_i - raw asynchronous button
//                Rb_o  - debounced button level
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic Rb_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_rb    <= 1'b0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_rb) begin
        // Agreement (including a bounce back) restarts the qualification
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // This edge is the DEBOUNCE_CYCLES-th consecutive disagreement
        r_rb  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign Rb_o = r_rb;

endmodule : button_debounce
`default_nettype wire

// File: rtl/dice_roller.sv
`default_nettype none
// ============================================================================
//  Module      : dice_roller
//  Description : Front end of the dice game controller. Debounces the roll
//                button, runs two cascaded mod-6 die counters while roll_i is
//                high and latches their total with a one-cycle strobe when
//                rolling stops.
//  Ports       : clk, rst (sync, active-high)
//                btn_i       - raw roll button
//                roll_i      - roll request from the controller
//                Rb_o        - debounced button level
//                die1_o/2_o  - die faces, 1..6
//                sum_o       - latched die total, 2..12
//                sum_valid_o - one-cycle strobe, sum_o new this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module dice_roller
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_i,
  input  logic             roll_i,
  output logic             Rb_o,
  output logic [DIE_W-1:0] die1_o,
  output logic [DIE_W-1:0] die2_o,
  output logic [SUM_W-1:0] sum_o,
  output logic             sum_valid_o
);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_strobe;
  logic [DIE_W-1:0] r_die1;
  logic [DIE_W-1:0] r_die2;
  logic [SUM_W-1:0] r_sum;
  logic             r_valid;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_i),
    .Rb_o  (Rb_o)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next state; the strobe fires on the edge that leaves ROLLING
  always_comb begin
    w_next_state = r_state;
    w_strobe     = 1'b0;
    case (r_state)
      IDLE: begin
        if (roll_i) w_next_state = ROLLING;
      end
      ROLLING: begin
        if (!roll_i) begin
          w_next_state = IDLE;
          w_strobe     = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Cascaded die counters: die2 steps on the die1 6->1 wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_die1 <= DIE_MIN;
      r_die2 <= DIE_MIN;
    end else if (roll_i) begin
      r_die1 <= die_next(r_die1);
      if (r_die1 == DIE_MAX) r_die2 <= die_next(r_die2);
    end
  end

  // Total is captured only on the strobe edge, using the held dice values
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= SUM_W'(2);
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_strobe;
      if (w_strobe) r_sum <= SUM_W'(r_die1) + SUM_W'(r_die2);
    end
  end

  assign die1_o      = r_die1;
  assign die2_o      = r_die2;
  assign sum_o       = r_sum;
  assign sum_valid_o = r_valid;

endmodule : dice_roller
`default_nettype wire

// File: tb/tb_dice_roller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dice_roller
//  Description : Self-checking bench for dice_roller. Directed scenarios plus
//                a randomized run compared against a behavioural model that
//                tracks the total roll count (mod 36) and button history.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dice_roller;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       btn_i;
  logic       roll_i;
  logic       Rb_o;
  logic [2:0] die1_o;
  logic [2:0] die2_o;
  logic [3:0] sum_o;
  logic       sum_valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state (values after the most recent clock edge)
  int m_n;        // roll edges since reset, mod 36
  bit m_rolling;  // last edge sampled roll_i high
  int m_sum;
  bit m_valid;
  bit m_hist[2];  // btn_i samples from the last two edges, [0] newest
  bit m_rb;
  int m_run;      // consecutive edges synchronized button differed from Rb

  dice_roller #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_i       (btn_i),
    .roll_i      (roll_i),
    .Rb_o        (Rb_o),
    .die1_o      (die1_o),
    .die2_o      (die2_o),
    .sum_o       (sum_o),
    .sum_valid_o (sum_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_die1();
    return (m_n % 6) + 1;
  endfunction

  function automatic int m_die2();
    return ((m_n / 6) % 6) + 1;
  endfunction

  // Advance the model by one clock edge using the inputs about to be sampled
  task automatic model_edge();
    bit bs;
    if (rst) begin
      m_n = 0; m_rolling = 0; m_sum = 2; m_valid = 0;
      m_hist[0] = 0; m_hist[1] = 0; m_rb = 0; m_run = 0;
    end else begin
      bs = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = btn_i;
      if (bs == m_rb) m_run = 0;
      else begin
        m_run++;
        if (m_run == D) begin
          m_rb  = bs;
          m_run = 0;
        end
      end
      m_valid = m_rolling && !roll_i;
      if (m_valid) m_sum = m_die1() + m_die2();
      if (roll_i) m_n = (m_n + 1) % 36;
      m_rolling = roll_i;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; roll_i = 0; btn_i = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (Rb_o !== 1'b0 || die1_o !== 3'd1 || die2_o !== 3'd1 ||
        sum_o !== 4'd2 || sum_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: Rb=%0b die=(%0d,%0d) sum=%0d valid=%0b, want 0 (1,1) 2 0",
               Rb_o, die1_o, die2_o, sum_o, sum_valid_o);
    end
  endtask

  task automatic test_debounce();
    bit pat[4] = '{1, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      btn_i = pat[i];
      tick();
      n_checks++;
      if (Rb_o !== 1'b0) begin
        n_fail++;
        $display("FAIL debounce_bounce[%0d]: Rb=%0b want 0", i, Rb_o);
      end
    end
    btn_i = 1;
    for (int i = 1; i <= 2 + D; i++) begin
      tick();
      n_checks++;
      if (Rb_o !== (i == 2 + D)) begin
        n_fail++;
        $display("FAIL debounce_rise[%0d]: Rb=%0b want %0b", i, Rb_o, (i == 2 + D));
      end
    end
    btn_i = 0;
    for (int i = 1; i <= 2 + D; i++) begin
      tick();
      n_checks++;
      if (Rb_o !== (i < 2 + D)) begin
        n_fail++;
        $display("FAIL debounce_fall[%0d]: Rb=%0b want %0b", i, Rb_o, (i < 2 + D));
      end
    end
  endtask

  // Roll for n edges from reset, stop, and check the strobe and its drop
  task automatic roll_and_check(input string name, input int n,
                                input int e1, input int e2, input int es);
    do_reset();
    roll_i = 1;
    for (int i = 0; i < n; i++) begin
      tick();
      n_checks++;
      if (sum_valid_o !== 1'b0 || sum_o !== 4'd2) begin
        n_fail++;
        $display("FAIL %s_rolling[%0d]: valid=%0b sum=%0d want 0 2", name, i, sum_valid_o, sum_o);
      end
    end
    roll_i = 0;
    tick();
    n_checks++;
    if (die1_o !== 3'(e1) || die2_o !== 3'(e2) || sum_o !== 4'(es) || sum_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_strobe: die=(%0d,%0d) sum=%0d valid=%0b want (%0d,%0d) %0d 1",
               name, die1_o, die2_o, sum_o, sum_valid_o, e1, e2, es);
    end
    tick();
    n_checks++;
    if (sum_valid_o !== 1'b0 || sum_o !== 4'(es)) begin
      n_fail++;
      $display("FAIL %s_after: valid=%0b sum=%0d want 0 %0d", name, sum_valid_o, sum_o, es);
    end
  endtask

  task automatic test_rolls();
    roll_and_check("three_step", 3, 4, 1, 5);
    roll_and_check("wrap6", 6, 1, 2, 3);
    roll_and_check("wrap35", 35, 6, 6, 12);
    roll_and_check("wrap36", 36, 1, 1, 2);
  endtask

  task automatic test_reset_mid_roll();
    int strobes = 0;
    do_reset();
    roll_i = 1;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    n_checks++;
    if (die1_o !== 3'd1 || die2_o !== 3'd1 || sum_valid_o !== 1'b0 || sum_o !== 4'd2) begin
      n_fail++;
      $display("FAIL midrst_reset: die=(%0d,%0d) sum=%0d valid=%0b want (1,1) 2 0",
               die1_o, die2_o, sum_o, sum_valid_o);
    end
    tick(); strobes += sum_valid_o;
    tick(); strobes += sum_valid_o;
    n_checks++;
    if (die1_o !== 3'd3 || die2_o !== 3'd1) begin
      n_fail++;
      $display("FAIL midrst_dice: die=(%0d,%0d) want (3,1)", die1_o, die2_o);
    end
    roll_i = 0;
    tick(); strobes += sum_valid_o;
    n_checks++;
    if (sum_o !== 4'd4 || sum_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_sum: sum=%0d valid=%0b want 4 1", sum_o, sum_valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); strobes += sum_valid_o;
    end
    n_checks++;
    if (strobes != 1) begin
      n_fail++;
      $display("FAIL midrst_strobes: count=%0d want 1", strobes);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    roll_i = 1; tick(); tick();
    roll_i = 0; tick();
    n_checks++;
    if (sum_o !== 4'd4 || sum_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: sum=%0d valid=%0b want 4 1", sum_o, sum_valid_o);
    end
    roll_i = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (sum_o !== 4'd4 || sum_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_hold[%0d]: sum=%0d valid=%0b want 4 0", i, sum_o, sum_valid_o);
      end
    end
    roll_i = 0; tick();
    n_checks++;
    if (sum_o !== 4'd6 || sum_valid_o !== 1'b1 || die1_o !== 3'd5 || die2_o !== 3'd1) begin
      n_fail++;
      $display("FAIL b2b_second: sum=%0d valid=%0b die=(%0d,%0d) want 6 1 (5,1)",
               sum_o, sum_valid_o, die1_o, die2_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 4) == 0) roll_i = ~roll_i;
      if ($urandom_range(0, 5) == 0) btn_i = ~btn_i;
      tick();
      n_checks++;
      if (Rb_o !== m_rb || die1_o !== 3'(m_die1()) || die2_o !== 3'(m_die2()) ||
          sum_o !== 4'(m_sum) || sum_valid_o !== m_valid) begin
        n_fail++;
        $display("FAIL random[%0d]: Rb=%0b die=(%0d,%0d) sum=%0d valid=%0b want %0b (%0d,%0d) %0d %0b",
                 i, Rb_o, die1_o, die2_o, sum_o, sum_valid_o,
                 m_rb, m_die1(), m_die2(), m_sum, m_valid);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; roll_i = 0; btn_i = 0;
    test_reset();
    test_debounce();
    test_rolls();
    test_reset_mid_roll();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dice_roller
`default_nettype wire
